// File: rtl/data_buffer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : data_buffer_arbiter
//  Description : Byte buffer in an external single-port SRAM, shared by an RX
//                writer, a TX reader and a host read/write port. One SRAM
//                access per transaction, with overflow/underflow signalling
//                and a flush. Optional macro BUF_RR_ARB_EN makes tx/host
//                alternate round-robin (otherwise fixed rx > tx > host).
//  Revision    : 1.0  initial release
// ============================================================================
module data_buffer_arbiter #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              rx_req,
    input  logic [7:0]        rx_wdata,
    input  logic              tx_req,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [7:0]        host_wdata,
    output logic              rx_ack,
    output logic              tx_ack,
    output logic              host_ack,
    output logic [7:0]        rd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic [6:0]        buffer_occupancy,
    output logic              overflow,
    output logic              underflow,
    output logic              busy
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WRITE = 2'd1;
    localparam logic [1:0] c_READ  = 2'd2;
    localparam logic [1:0] c_RDATA = 2'd3;

    localparam logic [1:0] c_G_RX   = 2'd0;
    localparam logic [1:0] c_G_TX   = 2'd1;
    localparam logic [1:0] c_G_HOST = 2'd2;

    localparam logic [6:0]        c_FULL = 7'(DEPTH);
    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);

    logic [1:0]        r_state;
    logic [1:0]        r_grant;
    logic [7:0]        r_wdata;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [6:0]        r_occ;
    logic [7:0]        r_rd_data;
    logic              r_rx_ack;
    logic              r_tx_ack;
    logic              r_host_ack;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_idle_ready;
    logic              w_tx_first;
    logic              w_pick_rx;
    logic              w_pick_tx;
    logic              w_pick_host;
    logic [1:0]        w_grant;

`ifdef BUF_RR_ARB_EN
    // 1 = host won last, so tx goes next
    logic              r_last_grant;

    // Track the last tx/host winner for round-robin alternation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (r_tx_ack) begin
            r_last_grant <= 1'b0;
        end else if (r_host_ack) begin
            r_last_grant <= 1'b1;
        end
    end
`endif

    // Combinational winner selection. Arbitration is held off in the cycle an
    // ack is visible, because the completed requester still holds its request
    // until it has seen that ack.
    always_comb begin
        w_idle_ready = (r_state == c_IDLE) && !(r_rx_ack || r_tx_ack || r_host_ack);
`ifdef BUF_RR_ARB_EN
        w_tx_first   = r_last_grant;
`else
        w_tx_first   = 1'b1;
`endif
        w_pick_rx    = rx_req;
        w_pick_tx    = !rx_req && tx_req && (!host_req || w_tx_first);
        w_pick_host  = !rx_req && host_req && !w_pick_tx;
        w_grant      = w_pick_rx ? c_G_RX : (w_pick_tx ? c_G_TX : c_G_HOST);
    end

    // SRAM strobes follow the state; a full buffer or a flush keeps the SRAM untouched
    assign mem_we    = (r_state == c_WRITE) && (r_occ != c_FULL) && !flush && !rst;
    assign mem_re    = (r_state == c_READ) && !flush && !rst;
    assign mem_addr  = (r_state == c_WRITE) ? r_wr_ptr : r_rd_ptr;
    assign mem_wdata = r_wdata;

    assign rx_ack           = r_rx_ack;
    assign tx_ack           = r_tx_ack;
    assign host_ack         = r_host_ack;
    assign rd_data          = r_rd_data;
    assign buffer_occupancy = r_occ;
    assign overflow         = r_overflow;
    assign underflow        = r_underflow;
    assign busy             = (r_state != c_IDLE);

    // Transaction state machine, pointers, occupancy and completion pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_grant     <= c_G_RX;
            r_wdata     <= 8'h00;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= 7'd0;
            r_rd_data   <= 8'h00;
            r_rx_ack    <= 1'b0;
            r_tx_ack    <= 1'b0;
            r_host_ack  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_rx_ack    <= 1'b0;
            r_tx_ack    <= 1'b0;
            r_host_ack  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            if (flush) begin
                // Abort anything in flight without an ack; held requests re-arbitrate
                r_state  <= c_IDLE;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_occ    <= 7'd0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (w_idle_ready && (rx_req || tx_req || host_req)) begin
                            r_grant <= w_grant;
                            if (w_pick_rx) begin
                                r_wdata <= rx_wdata;
                                r_state <= c_WRITE;
                            end else if (w_pick_host && host_we) begin
                                r_wdata <= host_wdata;
                                r_state <= c_WRITE;
                            end else begin
                                // Empty buffer: skip the SRAM read entirely
                                r_state <= (r_occ == 7'd0) ? c_RDATA : c_READ;
                            end
                        end
                    end
                    c_WRITE: begin
                        if (r_occ == c_FULL) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
                            r_occ    <= r_occ + 7'd1;
                        end
                        r_rx_ack   <= (r_grant == c_G_RX);
                        r_host_ack <= (r_grant == c_G_HOST);
                        r_state    <= c_IDLE;
                    end
                    c_READ: begin
                        r_state <= c_RDATA;
                    end
                    c_RDATA: begin
                        if (r_occ == 7'd0) begin
                            r_underflow <= 1'b1;
                        end else begin
                            r_rd_data <= mem_rdata;
                            r_rd_ptr  <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
                            r_occ     <= r_occ - 7'd1;
                        end
                        r_tx_ack   <= (r_grant == c_G_TX);
                        r_host_ack <= (r_grant == c_G_HOST);
                        r_state    <= c_IDLE;
                    end
                    default: begin
                        r_state <= c_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_buffer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_buffer_arbiter
//  Description : Self-checking bench for data_buffer_arbiter. A queue-based
//                byte FIFO model supplies expected data, flags, latencies and
//                SRAM addresses; a simple SRAM model serves the memory port.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_data_buffer_arbiter;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              rx_req = 1'b0;
    logic [7:0]        rx_wdata = 8'h00;
    logic              tx_req = 1'b0;
    logic              host_req = 1'b0;
    logic              host_we = 1'b0;
    logic [7:0]        host_wdata = 8'h00;
    logic              rx_ack, tx_ack, host_ack;
    logic [7:0]        rd_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we, mem_re;
    logic [7:0]        mem_rdata = 8'h00;
    logic [6:0]        buffer_occupancy;
    logic              overflow, underflow, busy;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: byte FIFO plus expected SRAM slot indices
    logic [7:0] q[$];
    int         m_wr = 0;
    int         m_rd = 0;
    logic [7:0] m_last_rd = 8'h00;

    logic [7:0] sram [DEPTH];

    data_buffer_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .rx_req(rx_req), .rx_wdata(rx_wdata), .tx_req(tx_req),
        .host_req(host_req), .host_we(host_we), .host_wdata(host_wdata),
        .rx_ack(rx_ack), .tx_ack(tx_ack), .host_ack(host_ack),
        .rd_data(rd_data), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .buffer_occupancy(buffer_occupancy),
        .overflow(overflow), .underflow(underflow), .busy(busy)
    );

    always #5 clk = ~clk;

    // Single-port SRAM with one cycle of read latency
    always @(posedge clk) begin
        if (mem_we) sram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= sram[mem_addr];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        q.delete();
        m_wr = 0;
        m_rd = 0;
        m_last_rd = 8'h00;
    endtask

    // Expected outcome of one transaction, derived from FIFO semantics
    task automatic model_op(input bit is_wr, input logic [7:0] d,
                            output int e_lat, output logic e_ovf, output logic e_unf,
                            output logic e_we, output logic e_re,
                            output logic [ADDR_W-1:0] e_addr, output logic [7:0] e_rd);
        e_ovf = 1'b0; e_unf = 1'b0; e_we = 1'b0; e_re = 1'b0; e_addr = '0;
        e_rd = m_last_rd;
        if (is_wr) begin
            e_lat = 2;
            if (q.size() == DEPTH) begin
                e_ovf = 1'b1;
            end else begin
                e_we = 1'b1;
                e_addr = ADDR_W'(m_wr);
                q.push_back(d);
                m_wr = (m_wr + 1) % DEPTH;
            end
        end else if (q.size() == 0) begin
            e_lat = 2;
            e_unf = 1'b1;
        end else begin
            e_lat = 3;
            e_re = 1'b1;
            e_addr = ADDR_W'(m_rd);
            e_rd = q.pop_front();
            m_rd = (m_rd + 1) % DEPTH;
            m_last_rd = e_rd;
        end
    endtask

    // One transaction from a single requester (0 rx, 1 tx, 2 host)
    task automatic do_txn(input int who, input logic we, input logic [7:0] d,
                          output int lat, output logic g_ovf, output logic g_unf,
                          output logic [7:0] g_rd, output logic s_we, output logic s_re,
                          output logic [ADDR_W-1:0] g_addr, output logic [7:0] g_wd);
        lat = 0; g_ovf = 1'b0; g_unf = 1'b0; g_rd = 8'h00;
        s_we = 1'b0; s_re = 1'b0; g_addr = '0; g_wd = 8'h00;
        @(posedge clk); #1;
        case (who)
            0: begin rx_req = 1'b1; rx_wdata = d; end
            1: tx_req = 1'b1;
            default: begin host_req = 1'b1; host_we = we; host_wdata = d; end
        endcase
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (mem_we) begin s_we = 1'b1; g_addr = mem_addr; g_wd = mem_wdata; end
            if (mem_re) begin s_re = 1'b1; g_addr = mem_addr; end
            if ((who == 0 && rx_ack) || (who == 1 && tx_ack) || (who == 2 && host_ack)) begin
                lat = n; g_ovf = overflow; g_unf = underflow; g_rd = rd_data;
                break;
            end
        end
        rx_req = 1'b0; tx_req = 1'b0; host_req = 1'b0; host_we = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1; flush = 1'b0;
        rx_req = 1'b0; tx_req = 1'b0; host_req = 1'b0; host_we = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Write-and-model helper for preloading; results are checked elsewhere
    task automatic preload(input logic [7:0] d);
        int el, l; logic a, b, c, e, f, g, h; logic [ADDR_W-1:0] ea, ga; logic [7:0] er, gr, gw;
        model_op(1'b1, d, el, a, b, c, e, ea, er);
        do_txn(0, 1'b1, d, l, f, g, gr, h, h, ga, gw);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b1;
        rx_req = 1'b0; tx_req = 1'b0; host_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (buffer_occupancy !== 7'd0) $display("FAIL reset_occ: got %0d expected 0", buffer_occupancy); else n_pass++;
        n_total++; if ({rx_ack, tx_ack, host_ack} !== 3'b000) $display("FAIL reset_acks: got %b expected 000", {rx_ack, tx_ack, host_ack}); else n_pass++;
        n_total++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data: got %0h expected 0", rd_data); else n_pass++;
        n_total++; if ({mem_we, mem_re, overflow, underflow, busy} !== 5'b0) $display("FAIL reset_flags: got %b expected 00000", {mem_we, mem_re, overflow, underflow, busy}); else n_pass++;
        rst = 1'b0; flush = 1'b0;
        model_reset();
    endtask

    task automatic test_write_basic();
        int lat; logic ov, un, swe, sre; logic [7:0] rd, wd; logic [ADDR_W-1:0] ad;
        reset_dut();
        q.push_back(8'hA5); m_wr = 1;
        do_txn(0, 1'b1, 8'hA5, lat, ov, un, rd, swe, sre, ad, wd);
        n_total++; if (lat !== 2) $display("FAIL wr_latency: got %0d expected 2", lat); else n_pass++;
        n_total++; if (swe !== 1'b1 || ad !== 6'd0 || wd !== 8'hA5) $display("FAIL wr_sram: got we=%b addr=%0d data=%0h expected we=1 addr=0 data=a5", swe, ad, wd); else n_pass++;
        n_total++; if (buffer_occupancy !== 7'd1) $display("FAIL wr_occ: got %0d expected 1", buffer_occupancy); else n_pass++;
    endtask

    task automatic test_read_basic();
        int lat; logic ov, un, swe, sre; logic [7:0] rd, wd; logic [ADDR_W-1:0] ad;
        reset_dut();
        preload(8'h11);
        preload(8'h22);
        do_txn(1, 1'b0, 8'h00, lat, ov, un, rd, swe, sre, ad, wd);
        void'(q.pop_front()); m_rd = 1; m_last_rd = 8'h11;
        n_total++; if (sre !== 1'b1 || ad !== 6'd0) $display("FAIL rd_sram: got re=%b addr=%0d expected re=1 addr=0", sre, ad); else n_pass++;
        n_total++; if (lat !== 3) $display("FAIL rd_latency: got %0d expected 3", lat); else n_pass++;
        n_total++; if (rd !== 8'h11) $display("FAIL rd_data: got %0h expected 11", rd); else n_pass++;
        n_total++; if (buffer_occupancy !== 7'd1) $display("FAIL rd_occ: got %0d expected 1", buffer_occupancy); else n_pass++;
    endtask

    task automatic test_overflow();
        int lat; logic ov, un, swe, sre; logic [7:0] rd, wd; logic [ADDR_W-1:0] ad;
        reset_dut();
        for (int i = 0; i < DEPTH; i++) preload(8'(i + 8'h40));
        do_txn(0, 1'b1, 8'h5A, lat, ov, un, rd, swe, sre, ad, wd);
        n_total++; if (lat !== 2 || ov !== 1'b1) $display("FAIL ovf_pulse: got lat=%0d ovf=%b expected lat=2 ovf=1", lat, ov); else n_pass++;
        n_total++; if (swe !== 1'b0) $display("FAIL ovf_sram_untouched: got we=%b expected 0", swe); else n_pass++;
        n_total++; if (buffer_occupancy !== 7'd64) $display("FAIL ovf_occ: got %0d expected 64", buffer_occupancy); else n_pass++;
        do_txn(2, 1'b0, 8'h00, lat, ov, un, rd, swe, sre, ad, wd);
        void'(q.pop_front()); m_rd = 1; m_last_rd = 8'h40;
        n_total++; if (rd !== 8'h40) $display("FAIL ovf_first_byte: got %0h expected 40", rd); else n_pass++;
        q.push_back(8'hC3); m_wr = 1;
        do_txn(0, 1'b1, 8'hC3, lat, ov, un, rd, swe, sre, ad, wd);
        n_total++; if (swe !== 1'b1 || ad !== 6'd0) $display("FAIL wrap_wr_ptr: got we=%b addr=%0d expected we=1 addr=0", swe, ad); else n_pass++;
        n_total++; if (buffer_occupancy !== 7'd64) $display("FAIL wrap_occ: got %0d expected 64", buffer_occupancy); else n_pass++;
    endtask

    task automatic test_underflow();
        int lat; logic ov, un, swe, sre; logic [7:0] rd, wd; logic [ADDR_W-1:0] ad;
        reset_dut();
        preload(8'h9C);
        do_txn(1, 1'b0, 8'h00, lat, ov, un, rd, swe, sre, ad, wd);
        void'(q.pop_front()); m_rd = 1; m_last_rd = 8'h9C;
        do_txn(2, 1'b0, 8'h00, lat, ov, un, rd, swe, sre, ad, wd);
        n_total++; if (lat !== 2 || un !== 1'b1) $display("FAIL unf_pulse: got lat=%0d unf=%b expected lat=2 unf=1", lat, un); else n_pass++;
        n_total++; if (rd !== 8'h9C) $display("FAIL unf_rd_hold: got %0h expected 9c", rd); else n_pass++;
        n_total++; if (sre !== 1'b0 || buffer_occupancy !== 7'd0) $display("FAIL unf_state: got re=%b occ=%0d expected re=0 occ=0", sre, buffer_occupancy); else n_pass++;
    endtask

    task automatic test_priority();
        int exp_order[$]; int got_order[$];
        int tl, hl, tx_left, host_left; bit last_host; bit rx_done;
        int el; logic a, b, c, e; logic [ADDR_W-1:0] ea; logic [7:0] er;
        reset_dut();
        preload(8'h31); preload(8'h32); preload(8'h33);
        // Expected grant order: rx first, then tx/host by the configured rule
        exp_order.push_back(0);
        tl = 2; hl = 1; last_host = 1'b1;
        while (tl > 0 || hl > 0) begin
`ifdef BUF_RR_ARB_EN
            if (tl > 0 && (hl == 0 || last_host)) begin exp_order.push_back(1); tl--; last_host = 1'b0; end
            else begin exp_order.push_back(2); hl--; last_host = 1'b1; end
`else
            if (tl > 0) begin exp_order.push_back(1); tl--; end
            else begin exp_order.push_back(2); hl--; end
`endif
        end
        @(posedge clk); #1;
        rx_req = 1'b1; rx_wdata = 8'h44; tx_req = 1'b1; host_req = 1'b1; host_we = 1'b0;
        tx_left = 2; host_left = 1; rx_done = 1'b0;
        for (int n = 0; n < 80 && !(rx_done && tx_left == 0 && host_left == 0); n++) begin
            @(posedge clk); #1;
            if (rx_ack) begin
                got_order.push_back(0); rx_req = 1'b0; rx_done = 1'b1;
                model_op(1'b1, 8'h44, el, a, b, c, e, ea, er);
            end
            if (tx_ack || host_ack) begin
                got_order.push_back(tx_ack ? 1 : 2);
                model_op(1'b0, 8'h00, el, a, b, c, e, ea, er);
                n_total++; if (rd_data !== er) $display("FAIL prio_rd_data: got %0h expected %0h", rd_data, er); else n_pass++;
                if (tx_ack) begin tx_left--; if (tx_left == 0) tx_req = 1'b0; end
                if (host_ack) begin host_left--; if (host_left == 0) host_req = 1'b0; end
            end
        end
        rx_req = 1'b0; tx_req = 1'b0; host_req = 1'b0;
        n_total++; if (got_order.size() !== exp_order.size()) $display("FAIL prio_count: got %0d expected %0d", got_order.size(), exp_order.size()); else n_pass++;
        for (int i = 0; i < exp_order.size() && i < got_order.size(); i++) begin
            n_total++; if (got_order[i] !== exp_order[i]) $display("FAIL prio_order[%0d]: got %0d expected %0d", i, got_order[i], exp_order[i]); else n_pass++;
        end
        n_total++; if (buffer_occupancy !== 7'(q.size())) $display("FAIL prio_occ: got %0d expected %0d", buffer_occupancy, q.size()); else n_pass++;
    endtask

    task automatic test_flush();
        int lat; logic ov, un, swe, sre; logic [7:0] rd, wd; logic [ADDR_W-1:0] ad;
        bit found; bit seen_ack;
        reset_dut();
        for (int i = 0; i < 5; i++) preload(8'(8'h60 + i));
        @(posedge clk); #1;
        tx_req = 1'b1; found = 1'b0; seen_ack = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (tx_ack) seen_ack = 1'b1;
            if (mem_re) begin found = 1'b1; break; end
        end
        n_total++; if (!found) $display("FAIL flush_reach_read: got no READ expected READ"); else n_pass++;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        model_reset();
        n_total++; if (tx_ack !== 1'b0 || seen_ack) $display("FAIL flush_no_ack: got ack=%b expected 0", tx_ack | seen_ack); else n_pass++;
        n_total++; if (buffer_occupancy !== 7'd0 || busy !== 1'b0) $display("FAIL flush_state: got occ=%0d busy=%b expected occ=0 busy=0", buffer_occupancy, busy); else n_pass++;
        lat = 0; un = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (tx_ack) begin lat = n; un = underflow; break; end
        end
        tx_req = 1'b0;
        n_total++; if (lat !== 2 || un !== 1'b1) $display("FAIL flush_rearb_unf: got lat=%0d unf=%b expected lat=2 unf=1", lat, un); else n_pass++;
        q.push_back(8'h77); m_wr = 1;
        do_txn(0, 1'b1, 8'h77, lat, ov, un, rd, swe, sre, ad, wd);
        n_total++; if (swe !== 1'b1 || ad !== 6'd0) $display("FAIL flush_ptr_reset: got we=%b addr=%0d expected we=1 addr=0", swe, ad); else n_pass++;
    endtask

    task automatic test_random();
        reset_dut();
        for (int i = 0; i < 180; i++) begin
            bit is_wr; int who; logic [7:0] d;
            int lat, e_lat; logic ov, un, swe, sre, e_ov, e_un, e_we, e_re;
            logic [7:0] rd, wd, e_rd; logic [ADDR_W-1:0] ad, e_ad;
            is_wr = ($urandom_range(99) < ((i < 90) ? 90 : 10));
            d = 8'($urandom);
            if (is_wr) who = ($urandom_range(1) == 0) ? 0 : 2;
            else       who = ($urandom_range(1) == 0) ? 1 : 2;
            model_op(is_wr, d, e_lat, e_ov, e_un, e_we, e_re, e_ad, e_rd);
            do_txn(who, is_wr, d, lat, ov, un, rd, swe, sre, ad, wd);
            n_total++; if (lat !== e_lat) $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, lat, e_lat); else n_pass++;
            n_total++; if ({ov, un} !== {e_ov, e_un}) $display("FAIL rnd_flags[%0d]: got ovf/unf=%b%b expected %b%b", i, ov, un, e_ov, e_un); else n_pass++;
            n_total++; if ({swe, sre} !== {e_we, e_re}) $display("FAIL rnd_access[%0d]: got we/re=%b%b expected %b%b", i, swe, sre, e_we, e_re); else n_pass++;
            if (e_we || e_re) begin
                n_total++; if (ad !== e_ad) $display("FAIL rnd_addr[%0d]: got %0d expected %0d", i, ad, e_ad); else n_pass++;
            end
            if (e_we) begin
                n_total++; if (wd !== d) $display("FAIL rnd_wdata[%0d]: got %0h expected %0h", i, wd, d); else n_pass++;
            end
            if (!is_wr) begin
                n_total++; if (rd !== e_rd) $display("FAIL rnd_rd_data[%0d]: got %0h expected %0h", i, rd, e_rd); else n_pass++;
            end
            n_total++; if (buffer_occupancy !== 7'(q.size())) $display("FAIL rnd_occ[%0d]: got %0d expected %0d", i, buffer_occupancy, q.size()); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_overflow();
        test_underflow();
        test_priority();
        test_flush();
        test_random();
        test_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
